// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MiniRiscV controller: opcodes, FSM states,
// datapath select codes and the decoded instruction-class record.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_AUIPC, S_ALU_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
    } state_t;

    // One-hot instruction class; all-zero means the opcode is not accepted.
    typedef struct packed {
        logic r_type;
        logic i_type;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } inst_class_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       trap;
        logic       bus_err;
    } ctrl_out_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode into a one-hot instruction class; optional
// instruction groups can be compiled out and then decode as illegal.
module opcode_classifier
    import ctrl_pkg::*;
#(
    parameter int ENABLE_JUMP  = 1,
    parameter int ENABLE_UPPER = 1
) (
    input  logic [6:0]  opcode,
    output inst_class_t cls,
    output logic        illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_R:      cls.r_type = 1'b1;
            OPC_I:      cls.i_type = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL:    cls.jal    = (ENABLE_JUMP != 0);
            OPC_JALR:   cls.jalr   = (ENABLE_JUMP != 0);
            OPC_LUI:    cls.lui    = (ENABLE_UPPER != 0);
            OPC_AUIPC:  cls.auipc  = (ENABLE_UPPER != 0);
            default:    cls = '0;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MiniRiscV control FSM: fetch/decode/execute/memory/writeback over a
// shared ALU and memory port, with a memory-wait timeout and a sticky trap.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ENABLE_JUMP  = 1,
    parameter int ENABLE_UPPER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        br_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic        bus_err
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int CNT_W      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    // The trap fires in the stall cycle that would make the count equal MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             bus_err_q;
    logic [1:0]       alu_op_q;
    logic             alu_src_a_q, alu_src_b_q;
    inst_class_t      cls;
    logic             illegal;
    logic             mem_wait, timeout;
    ctrl_out_t        ctrl;
    logic             inst_unused;

    assign inst_unused = ^inst[31:7];

    opcode_classifier #(
        .ENABLE_JUMP (ENABLE_JUMP),
        .ENABLE_UPPER(ENABLE_UPPER)
    ) u_classifier (
        .opcode (inst[6:0]),
        .cls    (cls),
        .illegal(illegal)
    );

    assign mem_wait = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                      && !mem_ready;
    assign timeout  = TIMEOUT_EN && mem_wait && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (TIMEOUT_EN && mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // ALU_WB replays the operand selects of the execute state that preceded it.
    always_ff @(posedge clk) begin
        alu_op_q    <= ctrl.alu_op;
        alu_src_a_q <= ctrl.alu_src_a;
        alu_src_b_q <= ctrl.alu_src_b;
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_PLUS4;
                    next_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (illegal)                      next_state = S_TRAP;
                else if (cls.r_type)              next_state = S_EXEC_R;
                else if (cls.i_type)              next_state = S_EXEC_I;
                else if (cls.load || cls.store)   next_state = S_MEM_ADDR;
                else if (cls.branch)              next_state = S_BRANCH;
                else if (cls.jal)                 next_state = S_JAL;
                else if (cls.jalr)                next_state = S_JALR;
                else if (cls.lui)                 next_state = S_LUI;
                else                              next_state = S_AUIPC;
            end
            S_EXEC_R: begin
                ctrl.alu_op = ALU_OP_RTYPE;
                next_state  = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctrl.alu_op    = ALU_OP_ITYPE;
                ctrl.alu_src_b = 1'b1;
                next_state     = S_ALU_WB;
            end
            S_AUIPC: begin
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                next_state     = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_SEL_ALU;
                ctrl.alu_op    = alu_op_q;
                ctrl.alu_src_a = alu_src_a_q;
                ctrl.alu_src_b = alu_src_b_q;
                next_state     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.alu_src_b = 1'b1;
                next_state     = cls.store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_sel = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_SEL_MEM;
                next_state     = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.addr_sel = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_op = ALU_OP_BRANCH;
                if (br_cond) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_BRANCH;
                end
                next_state = S_FETCH;
            end
            S_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_SEL_LINK;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_BRANCH;
                next_state     = S_FETCH;
            end
            S_JALR: begin
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_SEL_LINK;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_SRC_ALU;
                next_state     = S_FETCH;
            end
            S_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_SEL_IMM;
                next_state     = S_FETCH;
            end
            S_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: next_state = S_TRAP;
        endcase
        ctrl.bus_err = bus_err_q;
        // A stalled wait cycle has no strobes, so only the transition changes here.
        if (timeout) next_state = S_TRAP;
        if (rst)     next_state = S_FETCH;
    end

    assign {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
            alu_op, reg_write, wb_sel, trap, bus_err} = rst ? ctrl_out_t'(0) : ctrl;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle comparison against an
// instruction-level schedule model, table vectors, random traffic and corner cases.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       trap;
        logic       bus_err;
    } obs_t;

    typedef struct {
        logic mr;
        obs_t exp;
    } step_t;

    typedef struct {
        logic [6:0] opc;
        logic       br;
        int         fs;
        int         ms;
        int         exp_rw;
        int         exp_pcw;
    } vec_t;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ready = 1'b0;
    logic        br_cond = 1'b0;
    logic [31:0] inst = '0;

    logic a_mem_req, a_mem_we, a_addr_sel, a_ir_write, a_pc_write, a_alu_src_a, a_alu_src_b;
    logic a_reg_write, a_trap, a_bus_err;
    logic [1:0] a_pc_src, a_alu_op, a_wb_sel;
    logic b_mem_req, b_mem_we, b_addr_sel, b_ir_write, b_pc_write, b_alu_src_a, b_alu_src_b;
    logic b_reg_write, b_trap, b_bus_err;
    logic [1:0] b_pc_src, b_alu_op, b_wb_sel;
    obs_t act_a, act_b;

    int errors = 0;
    int checks = 0;
    int rw_seen, pcw_seen;
    step_t q[$];

    always #5 clk = ~clk;

    // Full-featured controller with a short timeout.
    multicycle_controller #(.MEM_TIMEOUT(4), .ENABLE_JUMP(1), .ENABLE_UPPER(1)) dut_a (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .br_cond(br_cond),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .addr_sel(a_addr_sel), .ir_write(a_ir_write),
        .pc_write(a_pc_write), .pc_src(a_pc_src), .alu_src_a(a_alu_src_a),
        .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .reg_write(a_reg_write),
        .wb_sel(a_wb_sel), .trap(a_trap), .bus_err(a_bus_err)
    );

    // Reduced controller: no jumps, no upper-immediates, no timeout.
    multicycle_controller #(.MEM_TIMEOUT(0), .ENABLE_JUMP(0), .ENABLE_UPPER(0)) dut_b (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .br_cond(br_cond),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .addr_sel(b_addr_sel), .ir_write(b_ir_write),
        .pc_write(b_pc_write), .pc_src(b_pc_src), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .reg_write(b_reg_write),
        .wb_sel(b_wb_sel), .trap(b_trap), .bus_err(b_bus_err)
    );

    assign act_a = {a_mem_req, a_mem_we, a_addr_sel, a_ir_write, a_pc_write, a_pc_src,
                    a_alu_src_a, a_alu_src_b, a_alu_op, a_reg_write, a_wb_sel, a_trap, a_bus_err};
    assign act_b = {b_mem_req, b_mem_we, b_addr_sel, b_ir_write, b_pc_write, b_pc_src,
                    b_alu_src_a, b_alu_src_b, b_alu_op, b_reg_write, b_wb_sel, b_trap, b_bus_err};

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare 1 ns later, return at the rising edge.
    task automatic cyc(input logic r, input logic mr, input logic br, input logic [31:0] w,
                       input obs_t exp, input int which, input string name);
        obs_t act;
        @(negedge clk);
        rst = r;
        mem_ready = mr;
        br_cond = br;
        inst = w;
        #1;
        act = (which == 2) ? act_b : act_a;
        chk(name, act, exp);
        if (act.reg_write) rw_seen++;
        if (act.pc_write)  pcw_seen++;
        @(posedge clk);
    endtask

    task automatic do_reset(input int which);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, obs_t'(0), which, "reset");
    endtask

    task automatic push(input logic mr, input obs_t o);
        step_t s;
        s.mr = mr;
        s.exp = o;
        q.push_back(s);
    endtask

    // A memory wait of n stall cycles followed by completion, or a timeout trap.
    task automatic add_wait(input int n, input int tmo, input obs_t busy, input obs_t done,
                            inout bit dead);
        obs_t t;
        if (dead) return;
        if (tmo != 0 && n >= tmo) begin
            for (int i = 0; i < tmo; i++) push(1'b0, busy);
            t = '0;
            t.trap = 1'b1;
            t.bus_err = 1'b1;
            for (int i = 0; i < 4; i++) push(logic'(i % 2), t);
            dead = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) push(1'b0, busy);
            push(1'b1, done);
        end
    endtask

    // Reference model: expected control trace of one instruction, cycle by cycle.
    task automatic plan(input logic [6:0] opc, input logic br, input int fs, input int ms,
                        input bit full, input int tmo);
        obs_t o, busy, done;
        bit dead;
        bit bad;
        dead = 1'b0;
        q.delete();
        busy = '0;
        busy.mem_req = 1'b1;
        done = busy;
        done.ir_write = 1'b1;
        done.pc_write = 1'b1;
        add_wait(fs, tmo, busy, done, dead);
        if (dead) return;
        push(1'b1, obs_t'(0));
        bad = !(opc inside {OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUI})
              || (!full && (opc inside {OP_JAL, OP_JALR, OP_LUI, OP_AUI}));
        if (bad) begin
            o = '0;
            o.trap = 1'b1;
            for (int i = 0; i < 4; i++) push(logic'(i % 2), o);
            return;
        end
        o = '0;
        case (opc)
            OP_ADD: begin
                o.alu_op = 2'b10; push(1'b1, o);
                o.reg_write = 1'b1; push(1'b1, o);
            end
            OP_ADDI: begin
                o.alu_op = 2'b11; o.alu_src_b = 1'b1; push(1'b1, o);
                o.reg_write = 1'b1; push(1'b1, o);
            end
            OP_AUI: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 1'b1; push(1'b1, o);
                o.reg_write = 1'b1; push(1'b1, o);
            end
            OP_LW, OP_SW: begin
                o.alu_src_b = 1'b1; push(1'b1, o);
                busy = '0;
                busy.mem_req = 1'b1;
                busy.addr_sel = 1'b1;
                busy.mem_we = (opc == OP_SW);
                add_wait(ms, tmo, busy, busy, dead);
                if (!dead && opc == OP_LW) begin
                    o = '0; o.reg_write = 1'b1; o.wb_sel = 2'b01; push(1'b1, o);
                end
            end
            OP_BEQ: begin
                o.alu_op = 2'b01; o.pc_write = br; o.pc_src = br ? 2'b01 : 2'b00; push(1'b1, o);
            end
            OP_JAL: begin
                o.reg_write = 1'b1; o.wb_sel = 2'b10; o.pc_write = 1'b1; o.pc_src = 2'b01;
                push(1'b1, o);
            end
            OP_JALR: begin
                o.alu_src_b = 1'b1; o.reg_write = 1'b1; o.wb_sel = 2'b10;
                o.pc_write = 1'b1; o.pc_src = 2'b10; push(1'b1, o);
            end
            default: begin
                o.reg_write = 1'b1; o.wb_sel = 2'b11; push(1'b1, o);
            end
        endcase
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic br, input int fs, input int ms,
                             input int which, input string tag);
        logic [31:0] w;
        w = $urandom();
        w[6:0] = opc;
        plan(opc, br, fs, ms, which == 1, (which == 1) ? 4 : 0);
        rw_seen = 0;
        pcw_seen = 0;
        foreach (q[k]) cyc(1'b0, q[k].mr, br, w, q[k].exp, which, tag);
    endtask

    initial begin
        vec_t tbl[10];
        logic [6:0] ops[9];
        obs_t o;
        logic [31:0] w_sw;

        tbl[0] = '{OP_ADD,  1'b0, 0, 0, 1, 1};
        tbl[1] = '{OP_ADDI, 1'b0, 1, 0, 1, 1};
        tbl[2] = '{OP_LW,   1'b0, 0, 3, 1, 1};
        tbl[3] = '{OP_SW,   1'b0, 2, 3, 0, 1};
        tbl[4] = '{OP_BEQ,  1'b1, 0, 0, 0, 2};
        tbl[5] = '{OP_BEQ,  1'b0, 0, 0, 0, 1};
        tbl[6] = '{OP_JAL,  1'b0, 0, 0, 1, 2};
        tbl[7] = '{OP_JALR, 1'b0, 3, 0, 1, 2};
        tbl[8] = '{OP_LUI,  1'b0, 0, 0, 1, 1};
        tbl[9] = '{OP_AUI,  1'b0, 0, 0, 1, 1};
        ops = '{OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUI};

        do_reset(1);
        do_reset(2);

        foreach (tbl[i]) begin
            run_instr(tbl[i].opc, tbl[i].br, tbl[i].fs, tbl[i].ms, 1, $sformatf("vec%0d", i));
            chk_int($sformatf("vec%0d_reg_write_count", i), rw_seen, tbl[i].exp_rw);
            chk_int($sformatf("vec%0d_pc_write_count", i), pcw_seen, tbl[i].exp_pcw);
        end

        for (int i = 0; i < 150; i++) begin
            run_instr(ops[$urandom_range(0, 8)], logic'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1, "random");
        end

        run_instr(OP_LW, 1'b0, 0, 6, 1, "timeout_mem_rd");
        do_reset(1);
        run_instr(OP_ADD, 1'b0, 9, 0, 1, "timeout_fetch");
        do_reset(1);
        run_instr(OP_SW, 1'b0, 0, 7, 1, "timeout_mem_wr");
        do_reset(1);
        run_instr(OP_ADD, 1'b0, 0, 0, 1, "after_trap_reset");

        run_instr(7'b1111111, 1'b0, 0, 0, 1, "illegal_opcode");
        chk_int("illegal_no_reg_write", rw_seen, 0);
        do_reset(1);

        // Reset while a store is stalled waiting for memory.
        w_sw = 32'h00a12223;
        o = '0; o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, w_sw, o, 1, "wr_fetch");
        o = '0;
        cyc(1'b0, 1'b1, 1'b0, w_sw, o, 1, "wr_decode");
        o.alu_src_b = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, w_sw, o, 1, "wr_addr");
        o = '0; o.mem_req = 1'b1; o.mem_we = 1'b1; o.addr_sel = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, w_sw, o, 1, "wr_wait");
        cyc(1'b0, 1'b0, 1'b0, w_sw, o, 1, "wr_wait");
        cyc(1'b1, 1'b0, 1'b0, w_sw, obs_t'(0), 1, "wr_abort");
        o = '0; o.mem_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, w_sw, o, 1, "wr_refetch");
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, w_sw, o, 1, "wr_refetch_done");

        do_reset(2);
        run_instr(OP_ADD, 1'b0, 20, 0, 2, "b_no_timeout_fetch");
        run_instr(OP_SW, 1'b0, 0, 20, 2, "b_no_timeout_store");
        run_instr(OP_BEQ, 1'b1, 0, 0, 2, "b_branch");
        run_instr(OP_JAL, 1'b0, 0, 0, 2, "b_jal_disabled");
        chk_int("b_jal_no_reg_write", rw_seen, 0);
        do_reset(2);
        run_instr(OP_JALR, 1'b0, 0, 0, 2, "b_jalr_disabled");
        do_reset(2);
        run_instr(OP_LUI, 1'b0, 0, 0, 2, "b_lui_disabled");
        do_reset(2);
        run_instr(OP_AUI, 1'b0, 1, 0, 2, "b_auipc_disabled");
        do_reset(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle main decoder of the MiniRiscV CPU.
- A Moore/Mealy FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Extends the instruction set to the full RV32I control-flow and upper-immediate classes.
- Adds a memory ready handshake, a memory timeout, and a sticky trap for illegal opcodes.

Parameters:
- MEM_TIMEOUT, 16: maximum number of cycles to wait for mem_ready before trapping. 0 disables the timeout.
- ENABLE_JUMP, 1: when 1, jal/jalr are legal. When 0, they decode as illegal.
- ENABLE_UPPER, 1: when 1, lui/auipc are legal. When 0, they decode as illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- inst  in  32  current instruction register contents; only [6:0] is decoded.
- mem_ready  in  1  memory completes the current request this cycle.
- br_cond  in  1  ALU branch-compare result (taken).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable, valid with mem_req.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_write  out  1  latch inst and old_pc from memory.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 00 = PC+4, 01 = old_pc+imm, 10 = ALU result.
- alu_src_a  out  1  ALU operand A: 0 = rs1, 1 = old_pc.
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = imm.
- alu_op  out  2  00 = add (load/store/address), 01 = branch compare, 10 = R-type, 11 = I-type ALU.
- reg_write  out  1  register file write.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = MEM, 10 = old_pc+4, 11 = imm.
- trap  out  1  sticky: illegal opcode or memory timeout.
- bus_err  out  1  sticky: the trap was caused by a timeout.

Behaviour:
- Reset:
  - While rst=1, every output is 0; the next state is FETCH, the wait counter is 0, and trap/bus_err are cleared.
  - The first FETCH asserts mem_req in the cycle after rst deasserts.
- Defaults: all outputs not named below are 0 in each state.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle), classified by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
  - A disabled class (ENABLE_* = 0) also goes to TRAP.
- EXEC_R: alu_op=10, alu_src_b=0 -> ALU_WB.
- EXEC_I: alu_op=11, alu_src_b=1 -> ALU_WB.
- AUIPC: alu_op=00, alu_src_a=1, alu_src_b=1 -> ALU_WB.
- ALU_WB: reg_write=1, wb_sel=00, with the same ALU selects as the preceding state (registered copy) -> FETCH.
- MEM_ADDR: alu_op=00, alu_src_b=1. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD:
  - mem_req=1, addr_sel=1.
  - On mem_ready -> MEM_WB (reg_write=1, wb_sel=01) -> FETCH.
- MEM_WR:
  - mem_req=1, mem_we=1, addr_sel=1.
  - On mem_ready -> FETCH; there is no writeback.
- BRANCH: alu_op=01. If br_cond: pc_write=1, pc_src=01. Then -> FETCH.
- JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01 -> FETCH.
- JALR: alu_op=00, alu_src_b=1, reg_write=1, wb_sel=10, pc_write=1, pc_src=10 -> FETCH.
- LUI: reg_write=1, wb_sel=11 -> FETCH.
- Latency with zero-wait memory:
  - 3 cycles: branch, jal, jalr, lui.
  - 4 cycles: R/I-type, auipc, store.
  - 5 cycles: load.
  - Each memory stall cycle adds 1.
- Timeout:
  - The counter increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0, and resets on any state change.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP and set bus_err=1.
  - mem_ready arriving in that same cycle wins: the transfer completes and there is no trap.
- TRAP:
  - Terminal state; trap=1. All strobes are 0, so no PC, register or memory side effects occur.
  - Only rst leaves TRAP.
- Reset mid-operation: rst in any state, including a pending memory wait, aborts with all outputs 0 in that same cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants;
  - the state enum;
  - ALU_OP_*, WB_SEL_* and PC_SRC_* encodings.
- One combinational sub-module, opcode_classifier:
  - input: opcode plus the ENABLE_* parameters;
  - output: one-hot instruction class and an illegal flag.
- The FSM and timeout counter live in multicycle_controller.

Test Plan:
- add x3,x1,x2, mem_ready always 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4 with wb_sel=00, alu_op=10.
- lw, mem_ready low for 3 cycles in MEM_RD -> load completes in 8 cycles; reg_write with wb_sel=01 exactly once; no trap.
- beq twice, br_cond=1 then br_cond=0 -> pc_write with pc_src=01 only in the taken case; both complete in 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered after 4 stall cycles with trap=1, bus_err=1; both stay high until rst.
- Opcode 1111111, and jal with ENABLE_JUMP=0 -> TRAP after DECODE; trap=1, bus_err=0, no reg_write/pc_write/mem_we ever asserted.
- rst asserted during MEM_WR wait -> next cycle all outputs 0; after release, FETCH with mem_req=1.
